pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register for the pipelined core. Replaces fixed-field stage registers with a generic valid/ready stage that holds control, tag and N data words. Adds backpressure through a 2-entry skid buffer, synchronous flush and bubble squashing of control bits. It also provides a saturating stall counter. Instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_slot.sv | 29 ++
 rtl/pipe_stage_skid.sv | 157 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and default widths for the generic pipeline stage.
//   stage_state_t : occupancy FSM state of pipe_stage_skid (EMPTY, ONE, TWO)
//   DEF_*         : default widths used by the stage and its instantiators
//   payload_w()   : packed payload width {ctrl, tag, data words}
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    localparam int DEF_CTRL_W   = 9;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_TAG_W    = 5;
    localparam int DEF_NUM_DATA = 5;

    // Payload width for the default configuration.
    localparam int DEF_PAYLOAD_W = DEF_CTRL_W + DEF_TAG_W + DEF_NUM_DATA * DEF_DATA_W;

    // Payload width for an arbitrary configuration.
    function automatic int payload_w(input int ctrl_w, input int tag_w,
                                     input int num_data, input int data_w);
        return ctrl_w + tag_w + num_data * data_w;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: payload-wide storage register with load enable.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears the slot to zero
//   load_i : capture d_i on the next rising edge
//   d_i    : payload to capture
//   q_o    : stored payload
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: generic valid/ready pipeline stage register with a
// 2-entry skid buffer, synchronous flush, bubble squashing of the control
// bundle and a saturating stall counter.
//
// Ports:
//   clk        : clock, all state on the rising edge
//   reset      : asynchronous active-low reset
//   flush      : synchronous flush, stage is EMPTY after the next edge
//   valid_in   : upstream entry valid          ready_out : stage can accept
//   ctrl_in    : control bundle                tag_in    : destination tag
//   data_in    : NUM_DATA words, word k at [k*DATA_W +: DATA_W]
//   valid_out  : head entry valid              ready_in  : downstream accepts head
//   ctrl_out   : head control (0 when invalid) tag_out   : head tag
//   data_out   : head data words               stall_cnt : saturating stall cycles
//   state_o    : current occupancy state (debug observation)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 on that side (in_fire = valid_in & ready_out, out_fire = valid_out &
// ready_in). valid_out/ready_out depend only on registered state, never
// combinationally on valid_in/ready_in. Once an entry is offered upstream it
// is expected to be held until accepted; entries leave in strict FIFO order.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = DEF_CTRL_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_DATA = DEF_NUM_DATA,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic [CTRL_W-1:0]          ctrl_in,
    input  logic [TAG_W-1:0]           tag_in,
    input  logic [NUM_DATA*DATA_W-1:0] data_in,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [CTRL_W-1:0]          ctrl_out,
    output logic [TAG_W-1:0]           tag_out,
    output logic [NUM_DATA*DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]           stall_cnt,
    output stage_state_t               state_o
);

    localparam int DW = NUM_DATA * DATA_W;
    localparam int PW = payload_w(CTRL_W, TAG_W, NUM_DATA, DATA_W);

    stage_state_t    state_q, state_d;
    logic            valid_q, ready_q;
    logic            in_fire, out_fire;
    logic            main_load, skid_load, main_from_skid;
    logic [PW-1:0]   in_payload, main_d, main_q, skid_q;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign in_payload = {ctrl_in, tag_in, data_in};
    assign in_fire    = valid_in & ready_q;
    assign out_fire   = valid_q & ready_in;

    // Next state and slot load enables. Flush overrides every transfer; the
    // slots are left untouched since the state alone marks them empty.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_payload;

    // State plus registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != EMPTY);
            ready_q <= (state_d != TWO);
        end
    end

    // Saturating stall counter; flush does not clear it.
    always_comb begin
        stall_d = stall_q;
        if (valid_q && !ready_in && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    pipe_slot #(.W(PW)) u_main (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (main_load),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_slot #(.W(PW)) u_skid (
        .clk    (clk),
        .rst_n  (reset),
        .load_i (skid_load),
        .d_i    (in_payload),
        .q_o    (skid_q)
    );

    assign valid_out = valid_q;
    assign ready_out = ready_q;
    // Bubble squash: an invalid head must not carry live control bits.
    assign ctrl_out  = valid_q ? main_q[PW-1 -: CTRL_W] : '0;
    assign tag_out   = main_q[DW +: TAG_W];
    assign data_out  = main_q[DW-1:0];
    assign stall_cnt = stall_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: self-checking bench for pipe_stage_skid.
// Main instance uses default widths; a second instance uses CNT_W=4,
// NUM_DATA=2, DATA_W=32 for saturation and data packing checks.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (defaults) ----------------
    logic         flush, valid_in, ready_in, ready_out, valid_out;
    logic [8:0]   ctrl_in, ctrl_out;
    logic [4:0]   tag_in, tag_out;
    logic [319:0] data_in, data_out;
    logic [15:0]  stall_cnt;
    stage_state_t state_m;

    pipe_stage_skid dut (
        .clk(clk), .reset(rst_n), .flush(flush),
        .valid_in(valid_in), .ready_out(ready_out),
        .ctrl_in(ctrl_in), .tag_in(tag_in), .data_in(data_in),
        .valid_out(valid_out), .ready_in(ready_in),
        .ctrl_out(ctrl_out), .tag_out(tag_out), .data_out(data_out),
        .stall_cnt(stall_cnt), .state_o(state_m)
    );

    // ---------------- small DUT ----------------
    logic         s_flush, s_valid_in, s_ready_in, s_ready_out, s_valid_out;
    logic [8:0]   s_ctrl_in, s_ctrl_out;
    logic [4:0]   s_tag_in, s_tag_out;
    logic [63:0]  s_data_in, s_data_out;
    logic [3:0]   s_stall_cnt;
    stage_state_t state_s;

    pipe_stage_skid #(.CTRL_W(9), .DATA_W(32), .NUM_DATA(2), .TAG_W(5), .CNT_W(4)) dut_s (
        .clk(clk), .reset(rst_n), .flush(s_flush),
        .valid_in(s_valid_in), .ready_out(s_ready_out),
        .ctrl_in(s_ctrl_in), .tag_in(s_tag_in), .data_in(s_data_in),
        .valid_out(s_valid_out), .ready_in(s_ready_in),
        .ctrl_out(s_ctrl_out), .tag_out(s_tag_out), .data_out(s_data_out),
        .stall_cnt(s_stall_cnt), .state_o(state_s)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  exp_q[$];
    logic [15:0] exp_stall;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [8:0] ctrl_of(input logic [4:0] t);
        return {4'b1010, t};
    endfunction

    function automatic logic [319:0] mk_data(input logic [4:0] t);
        logic [319:0] d;
        for (int k = 0; k < 5; k++) d[k*64 +: 64] = {16'hC0DE, 16'(k), 27'd0, t};
        return d;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vi, input logic ri, input logic [4:0] t);
        valid_in = vi;
        ready_in = ri;
        tag_in   = t;
        ctrl_in  = ctrl_of(t);
        data_in  = mk_data(t);
    endtask

    typedef struct {
        logic       vi;
        logic       ri;
        logic [4:0] tag;
        logic       ev;
        logic       er;
        logic [4:0] etag;
        logic [15:0] estall;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic       hold;
        logic       in_f, out_f;
        logic [4:0] nt;

        // vectors: streaming 1..8, drain, then stall with skid fill
        for (int k = 0; k < 8; k++)
            vecs[k] = '{1'b1, 1'b1, 5'(k + 1), 1'b1, 1'b1, 5'(k + 1), 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 16'd0};
        vecs[9]  = '{1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 5'd1, 16'd0};
        vecs[10] = '{1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 5'd1, 16'd1};
        vecs[11] = '{1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 5'd1, 16'd2};
        vecs[12] = '{1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 5'd1, 16'd3};
        vecs[13] = '{1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd2, 16'd3};
        vecs[14] = '{1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 16'd3};
        vecs[15] = '{1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 16'd3};

        // reset held low with a live, all-ones entry offered
        rst_n = 1'b0;
        flush = 1'b0;
        valid_in = 1'b1; ready_in = 1'b0;
        ctrl_in = 9'h1FF; tag_in = 5'h1F; data_in = '1;
        s_flush = 1'b0; s_valid_in = 1'b0; s_ready_in = 1'b0;
        s_ctrl_in = '0; s_tag_in = '0; s_data_in = '0;
        repeat (3) step();
        chk("rst_valid", valid_out, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_ctrl", ctrl_out, 0);
        chk("rst_tag", tag_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_state", state_m, EMPTY);
        valid_in = 1'b0;
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", valid_out, 0);

        // table-driven vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].vi, vecs[i].ri, vecs[i].tag);
            step();
            chk($sformatf("vec%0d_valid", i), valid_out, vecs[i].ev);
            chk($sformatf("vec%0d_ready", i), ready_out, vecs[i].er);
            chk($sformatf("vec%0d_stall", i), stall_cnt, vecs[i].estall);
            chk($sformatf("vec%0d_ctrl", i), ctrl_out, vecs[i].ev ? ctrl_of(vecs[i].etag) : 9'd0);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_tag", i), tag_out, vecs[i].etag);
                chk($sformatf("vec%0d_data", i), data_out, mk_data(vecs[i].etag));
            end
        end

        // flush while both slots full and a new entry is offered
        drive(1'b1, 1'b0, 5'd10);
        step();
        chk("fl_fill1_tag", tag_out, 10);
        chk("fl_fill1_stall", stall_cnt, 3);
        drive(1'b1, 1'b0, 5'd11);
        step();
        chk("fl_two_ready", ready_out, 0);
        chk("fl_two_stall", stall_cnt, 4);
        drive(1'b1, 1'b0, 5'd12);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_valid", valid_out, 0);
        chk("fl_ctrl", ctrl_out, 0);
        chk("fl_ready", ready_out, 1);
        chk("fl_stall", stall_cnt, 5);
        drive(1'b0, 1'b1, 5'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_nothing_out", valid_out, 0);
        end
        drive(1'b1, 1'b1, 5'd13);
        step();
        chk("fl_next_valid", valid_out, 1);
        chk("fl_next_tag", tag_out, 13);
        chk("fl_next_ctrl", ctrl_out, ctrl_of(5'd13));
        drive(1'b0, 1'b1, 5'd0);
        step();
        chk("fl_drain", valid_out, 0);

        // asynchronous reset in the middle of a cycle with both slots full
        drive(1'b1, 1'b0, 5'd20);
        step();
        drive(1'b1, 1'b0, 5'd21);
        step();
        chk("ar_pre_ready", ready_out, 0);
        chk("ar_pre_stall", stall_cnt, 6);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", valid_out, 0);
        chk("ar_ready", ready_out, 1);
        chk("ar_ctrl", ctrl_out, 0);
        chk("ar_tag", tag_out, 0);
        chk("ar_stall", stall_cnt, 0);
        drive(1'b0, 1'b1, 5'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_after_valid", valid_out, 0);

        // random traffic against a 2-deep FIFO model
        exp_stall = '0;
        hold = 1'b0;
        nt = 5'd1;
        for (int c = 0; c < 300; c++) begin
            chk("rnd_valid", valid_out, exp_q.size() > 0);
            chk("rnd_ready", ready_out, exp_q.size() < 2);
            chk("rnd_stall", stall_cnt, exp_stall);
            if (exp_q.size() > 0) begin
                chk("rnd_tag", tag_out, exp_q[0]);
                chk("rnd_ctrl", ctrl_out, ctrl_of(exp_q[0]));
                chk("rnd_data", data_out, mk_data(exp_q[0]));
            end else begin
                chk("rnd_ctrl_squash", ctrl_out, 0);
            end
            if (!hold) begin
                valid_in = 1'($urandom_range(0, 1));
                if (valid_in) begin
                    tag_in = nt;
                    nt = nt + 5'd1;
                end
            end
            ready_in = ($urandom_range(0, 2) != 0);
            ctrl_in = ctrl_of(tag_in);
            data_in = mk_data(tag_in);
            in_f  = valid_in && (exp_q.size() < 2);
            out_f = (exp_q.size() > 0) && ready_in;
            if ((exp_q.size() > 0) && !ready_in) exp_stall = exp_stall + 16'd1;
            if (out_f) void'(exp_q.pop_front());
            if (in_f) exp_q.push_back(tag_in);
            hold = valid_in && !in_f;
            step();
        end
        drive(1'b0, 1'b1, 5'd0);

        // small instance: data packing and 4-bit stall saturation
        s_valid_in = 1'b1;
        s_ready_in = 1'b0;
        s_tag_in   = 5'd9;
        s_ctrl_in  = 9'h0F3;
        s_data_in  = 64'hDEADBEEF_01234567;
        step();
        s_valid_in = 1'b0;
        chk("s_valid", s_valid_out, 1);
        chk("s_data", s_data_out, 64'hDEADBEEF_01234567);
        chk("s_word0", s_data_out[31:0], 32'h01234567);
        chk("s_word1", s_data_out[63:32], 32'hDEADBEEF);
        chk("s_ctrl", s_ctrl_out, 9'h0F3);
        chk("s_stall0", s_stall_cnt, 0);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk($sformatf("s_stall%0d", k), s_stall_cnt, (k > 15) ? 15 : k);
        end
        s_ready_in = 1'b1;
        step();
        chk("s_drain_valid", s_valid_out, 0);
        chk("s_stall_hold", s_stall_cnt, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
